// File: rtl/psone_uart_gen.sv
// psone_uart_gen: parametrised full-duplex UART for the pad bridge; parity bit enabled by `define UART_PARITY_EN.
// Latency: oTX drops on the accept edge; RX flags rise 1 cycle after the mid-stop sample (+2 sync flops).
// Backpressure: none -- iTRAN_ST is ignored while oTRAN_BUSY, received bytes must be taken on oREC_END.
module psone_uart_gen #(
  parameter int CLK_DIV    = 1302,
  parameter int OVERSAMPLE = 4,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 2,
  parameter int PARITY_ODD = 0
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic                 iRX,
  output logic                 oTX,
  input  logic                 iTRAN_ST,
  input  logic [DATA_BITS-1:0] iTX_BYTE,
  output logic                 oTRAN_BUSY,
  output logic [DATA_BITS-1:0] oRX_BYTE,
  output logic                 oREC_END,
  output logic                 oREC_BUSY,
  output logic                 oREC_ER,
  output logic                 oPAR_ER
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_MID    = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0] HOLD_LAST = BIT_W'(1);
`ifdef UART_PARITY_EN
  localparam logic             PAR_ODD   = (PARITY_ODD != 0);
`endif

  if (CLK_DIV < 2 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("psone_uart_gen: illegal parameter set");
  end

  typedef enum logic [2:0] {
    T_IDLE,
    T_START,
    T_DATA,
`ifdef UART_PARITY_EN
    T_PAR,
`endif
    T_STOP
  } tx_state_t;

  typedef enum logic [3:0] {
    R_IDLE,
    R_START,
    R_DATA,
`ifdef UART_PARITY_EN
    R_PAR,
    R_PERR,
`endif
    R_STOP,
    R_DONE,
    R_ERR,
    R_HOLD
  } rx_state_t;

  // ---------------------------------------------------------------- TX
  tx_state_t            tx_state;
  logic [DIV_W-1:0]     tx_div;
  logic [OS_W-1:0]      tx_os;
  logic [BIT_W-1:0]     tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif
  logic                 tx_tick;
  logic                 tx_bit_end;

  assign tx_tick    = (tx_div == '0);
  assign tx_bit_end = tx_tick && (tx_os == OS_LAST);

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      tx_state   <= T_IDLE;
      tx_div     <= DIV_LAST;
      tx_os      <= '0;
      tx_bit     <= '0;
      tx_shift   <= '0;
`ifdef UART_PARITY_EN
      tx_par     <= 1'b0;
`endif
      oTX        <= 1'b1;
      oTRAN_BUSY <= 1'b0;
    end else if (tx_state == T_IDLE) begin
      if (iTRAN_ST) begin
        tx_state   <= T_START;
        tx_shift   <= iTX_BYTE;
        tx_div     <= DIV_LAST;
        tx_os      <= '0;
        tx_bit     <= '0;
`ifdef UART_PARITY_EN
        tx_par     <= (^iTX_BYTE) ^ PAR_ODD;
`endif
        oTX        <= 1'b0;
        oTRAN_BUSY <= 1'b1;
      end
    end else begin
      tx_div <= tx_tick ? DIV_LAST : tx_div - 1'b1;
      if (tx_tick) tx_os <= (tx_os == OS_LAST) ? '0 : tx_os + 1'b1;
      if (tx_bit_end) begin
        case (tx_state)
          T_START: begin
            tx_state <= T_DATA;
            oTX      <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end
          T_DATA: begin
            if (tx_bit == DATA_LAST) begin
              tx_bit   <= '0;
`ifdef UART_PARITY_EN
              tx_state <= T_PAR;
              oTX      <= tx_par;
`else
              tx_state <= T_STOP;
              oTX      <= 1'b1;
`endif
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              oTX      <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end
`ifdef UART_PARITY_EN
          T_PAR: begin
            tx_state <= T_STOP;
            oTX      <= 1'b1;
          end
`endif
          T_STOP: begin
            if (tx_bit == STOP_LAST) begin
              tx_state   <= T_IDLE;
              oTRAN_BUSY <= 1'b0;
            end else begin
              tx_bit <= tx_bit + 1'b1;
            end
          end
          default: begin
            tx_state   <= T_IDLE;
            oTX        <= 1'b1;
            oTRAN_BUSY <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- RX
  logic                 rx_meta;
  logic                 rxs;
  rx_state_t            rx_state;
  logic [DIV_W-1:0]     rx_div;
  logic [OS_W-1:0]      rx_os;
  logic [BIT_W-1:0]     rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_hold_done;
`ifdef UART_PARITY_EN
  logic                 rx_par_acc;
  logic                 rx_par_bad;
`endif
  logic                 rx_tick;
  logic                 rx_mid;
  logic                 rx_bit_end;

  assign rx_tick    = (rx_div == '0);
  assign rx_mid     = rx_tick && (rx_os == OS_MID);
  assign rx_bit_end = rx_tick && (rx_os == OS_LAST);
  assign oREC_BUSY  = (rx_state != R_IDLE);

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      rx_meta      <= 1'b1;
      rxs          <= 1'b1;
      rx_state     <= R_IDLE;
      rx_div       <= DIV_LAST;
      rx_os        <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_hold_done <= 1'b0;
      oRX_BYTE     <= '0;
      oREC_END     <= 1'b0;
      oREC_ER      <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_acc   <= 1'b0;
      rx_par_bad   <= 1'b0;
      oPAR_ER      <= 1'b0;
`endif
    end else begin
      rx_meta  <= iRX;
      rxs      <= rx_meta;
      oREC_END <= 1'b0;
      oREC_ER  <= 1'b0;
`ifdef UART_PARITY_EN
      oPAR_ER  <= 1'b0;
`endif
      // Free-running tick/phase counters while busy; state arms below override them on (re)start.
      if (rx_state != R_IDLE) begin
        rx_div <= rx_tick ? DIV_LAST : rx_div - 1'b1;
        if (rx_tick) rx_os <= (rx_os == OS_LAST) ? '0 : rx_os + 1'b1;
      end
      case (rx_state)
        R_IDLE: begin
          if (!rxs) begin
            rx_state   <= R_START;
            rx_div     <= DIV_LAST;
            rx_os      <= '0;
            rx_bit     <= '0;
`ifdef UART_PARITY_EN
            rx_par_acc <= 1'b0;
            rx_par_bad <= 1'b0;
`endif
          end
        end
        R_START: begin
          if (rx_mid) begin
            rx_os    <= '0;
            rx_state <= rxs ? R_IDLE : R_DATA;
          end
        end
        R_DATA: begin
          if (rx_bit_end) begin
            rx_shift   <= {rxs, rx_shift[DATA_BITS-1:1]};
`ifdef UART_PARITY_EN
            rx_par_acc <= rx_par_acc ^ rxs;
`endif
            if (rx_bit == DATA_LAST) begin
`ifdef UART_PARITY_EN
              rx_state <= R_PAR;
`else
              rx_state <= R_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        R_PAR: begin
          if (rx_bit_end) begin
            rx_par_bad <= rxs ^ rx_par_acc ^ PAR_ODD;
            rx_state   <= R_STOP;
          end
        end
`endif
        R_STOP: begin
          if (rx_bit_end) begin
            if (!rxs) begin
              rx_state <= R_ERR;
`ifdef UART_PARITY_EN
            end else if (rx_par_bad) begin
              rx_state <= R_PERR;
`endif
            end else begin
              rx_state <= R_DONE;
            end
          end
        end
        R_DONE: begin
          oRX_BYTE <= rx_shift;
          oREC_END <= 1'b1;
          rx_state <= R_IDLE;
        end
        R_ERR: begin
          oREC_ER      <= 1'b1;
          rx_state     <= R_HOLD;
          rx_div       <= DIV_LAST;
          rx_os        <= '0;
          rx_bit       <= '0;
          rx_hold_done <= 1'b0;
        end
`ifdef UART_PARITY_EN
        R_PERR: begin
          oPAR_ER      <= 1'b1;
          rx_state     <= R_HOLD;
          rx_div       <= DIV_LAST;
          rx_os        <= '0;
          rx_bit       <= '0;
          rx_hold_done <= 1'b0;
        end
`endif
        R_HOLD: begin
          // Two quiet bit periods, then the line must be back high before hunting for a start bit.
          if (rx_hold_done) begin
            if (rxs) rx_state <= R_IDLE;
          end else if (rx_bit_end) begin
            if (rx_bit == HOLD_LAST) rx_hold_done <= 1'b1;
            else                     rx_bit       <= rx_bit + 1'b1;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

`ifndef UART_PARITY_EN
  assign oPAR_ER = 1'b0;
`endif

endmodule
